// File: rtl/psum_collector.sv
// Cross-pass partial-sum accumulator: folds NUM_PASS passes of DEPTH partial sums
// from the PE column into a register buffer, then drains the tile over valid/ready.
module psum_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int NUM_PASS   = 4,
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PW        = $clog2(NUM_PASS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [PW-1:0]         pass_cnt,
    output logic                  tile_done
);

    typedef enum logic {ACCUM, DRAIN} state_t;

    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASS - 1);

    state_t                       state;
    logic [IW-1:0]                wr_idx;
    logic [IW-1:0]                rd_idx;
    logic signed [DATA_WIDTH-1:0] buffer [DEPTH];
    logic signed [DATA_WIDTH-1:0] in_data_s;

    // Two's-complement add that wraps modulo 2^DATA_WIDTH; no saturation by design.
    function automatic logic signed [DATA_WIDTH-1:0] add_wrap(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    assign in_data_s = $signed(in_data);
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign out_data  = (state == DRAIN) ? buffer[rd_idx] : '0;
    assign out_last  = (state == DRAIN) && (rd_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            wr_idx    <= '0;
            rd_idx    <= '0;
            pass_cnt  <= '0;
            tile_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            tile_done <= 1'b0;
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        // Pass 0 overwrites so nothing from the previous tile leaks in.
                        if (pass_cnt == '0) begin
                            buffer[wr_idx] <= in_data_s;
                        end else begin
                            buffer[wr_idx] <= add_wrap(buffer[wr_idx], in_data_s);
                        end
                        if (wr_idx == LAST_IDX) begin
                            wr_idx <= '0;
                            if (pass_cnt == LAST_PASS) begin
                                pass_cnt <= '0;
                                rd_idx   <= '0;
                                state    <= DRAIN;
                            end else begin
                                pass_cnt <= pass_cnt + PW'(1);
                            end
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx    <= '0;
                            state     <= ACCUM;
                            tile_done <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: stimulus pushes expected tile results,
// a negedge monitor pops and compares on every output handshake.
module tb_psum_collector;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int NP    = 4;
    localparam int PW    = $clog2(NP + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [PW-1:0] pass_cnt;
    logic          tile_done;

    psum_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_PASS(NP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .pass_cnt(pass_cnt), .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            hs_cnt = 0;
    int            tiles_drained = 0;
    int            ready_pct = 100;
    bit            saw_last = 0;
    bit            stall = 0;
    logic [DW-1:0] stall_data;
    logic          stall_last;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    // Output-side monitor: samples on the falling edge, handshakes complete on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            saw_last = 0;
            stall    = 0;
        end else begin
            check("tile_done", DW'(tile_done), DW'(saw_last));
            saw_last = 0;
            if (out_valid) check("in_ready_in_drain", DW'(in_ready), DW'(0));
            if (stall && out_valid) begin
                check("stall_data", out_data, stall_data);
                check("stall_last", DW'(out_last), DW'(stall_last));
            end
            stall = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", DW'(out_last), DW'(e.last));
                    hs_cnt++;
                    if (e.last) begin
                        saw_last = 1;
                        tiles_drained++;
                    end
                end
            end else if (out_valid) begin
                stall      = 1;
                stall_data = out_data;
                stall_last = out_last;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    task automatic check_reset_outputs();
        check("rst_in_ready", DW'(in_ready), DW'(1));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_last", DW'(out_last), DW'(0));
        check("rst_tile_done", DW'(tile_done), DW'(0));
        check("rst_out_data", out_data, DW'(0));
        check("rst_pass_cnt", DW'(pass_cnt), DW'(0));
    endtask

    // Presents one beat, waits for acceptance, then checks the pass counter status.
    task automatic send_beat(input logic [DW-1:0] d, input int exp_pass);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok) check("pass_cnt", DW'(pass_cnt), DW'(exp_pass));
        else fail_now("input_accept");
    endtask

    // mode 0: i+p, 1: 0x7FFFFFFF, 2: -5/+3 alternating passes, 3: random.
    task automatic run_tile(input int mode, input int gap_pct, input int rpct, input int abort_after);
        logic [DW-1:0] d [NP][DEPTH];
        logic [DW-1:0] sum;
        exp_t          e;
        int            start;
        bit            done;
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                case (mode)
                    0:       d[p][i] = DW'(i + p);
                    1:       d[p][i] = 32'h7FFF_FFFF;
                    2:       d[p][i] = (p % 2 == 0) ? -32'sd5 : 32'sd3;
                    default: d[p][i] = $urandom;
                endcase
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            case (mode)
                0:       sum = DW'(4 * i + 6);
                1, 2:    sum = 32'hFFFF_FFFC;
                default: begin
                    sum = '0;
                    for (int p = 0; p < NP; p++) sum = sum + d[p][i];
                end
            endcase
            e.data = sum;
            e.last = (i == DEPTH - 1);
            exp_q.push_back(e);
        end
        ready_pct = rpct;
        hs_cnt    = 0;
        start     = tiles_drained;
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(99) < gap_pct) begin
                    repeat ($urandom_range(3, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                send_beat(d[p][i], (i == DEPTH - 1) ? ((p == NP - 1) ? 0 : p + 1) : p);
            end
        end
        check("first_valid", DW'(out_valid), DW'(1));
        check("drain_in_ready", DW'(in_ready), DW'(0));
        if (abort_after > 0) begin
            done = 0;
            for (int n = 0; n < 500; n++) begin
                @(negedge clk);
                if (hs_cnt >= abort_after) begin
                    done = 1;
                    break;
                end
            end
            if (!done) fail_now("abort_wait");
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check_reset_outputs();
            exp_q.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
        end
        done = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            if (tiles_drained > start) begin
                done = 1;
                break;
            end
            in_valid = $urandom_range(1);
            in_data  = $urandom;
        end
        in_valid = 1'b0;
        if (!done) fail_now("drain_complete");
        check("queue_empty", DW'(exp_q.size()), DW'(0));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_tile(0, 0, 100, 0);
        run_tile(0, 30, 60, 0);
        run_tile(1, 0, 100, 0);
        run_tile(2, 10, 80, 0);
        run_tile(3, 0, 100, 0);
        run_tile(3, 20, 70, 0);
        run_tile(3, 0, 100, 5);
        run_tile(0, 0, 100, 0);
        run_tile(3, 25, 50, 0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Output-side counterpart of the PE (`pu`) array: consumes the `data_out` partial-sum stream from the PE column and performs cross-pass (input-channel) accumulation.
- Accumulates NUM_PASS passes of DEPTH partial sums each into a register buffer.
- Once the final pass lands, drains the finished tile downstream over a valid/ready stream.
- Sits between the PE array and the output/feature-map writer.

Parameters:
- DATA_WIDTH, 32, width of partial sums and results (two's-complement integer).
- DEPTH, 16, output positions per tile (buffer entries); must be ≥ 2.
- NUM_PASS, 4, passes accumulated per tile; must be ≥ 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  PE partial sum on in_data is valid.
- in_ready  output  1  collector accepts input this cycle.
- in_data  input  DATA_WIDTH  partial sum from the PE `data_out`.
- out_valid  output  1  result on out_data is valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  DATA_WIDTH  accumulated result for position rd_idx.
- out_last  output  1  marks result of position DEPTH-1 (last beat of tile).
- pass_cnt  output  clog2(NUM_PASS+1)  current pass index (status).
- tile_done  output  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset (async, rst_n=0), held until rst_n rises:
  - state=ACCUM; wr_idx=0; rd_idx=0; pass_cnt=0.
  - All buffer entries=0; out_valid=0; out_last=0; tile_done=0.
  - out_data=0; in_ready=1 (combinational from state).
- Input accept = in_valid && in_ready. Output accept = out_valid && out_ready.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On input accept:
    - pass_cnt==0: buf[wr_idx] <= in_data (overwrite, no stale data from previous tile).
    - pass_cnt>0: buf[wr_idx] <= buf[wr_idx] + in_data, truncated to DATA_WIDTH (wrap mod 2^DATA_WIDTH, no saturation, no overflow flag).
    - wr_idx increments. At wr_idx==DEPTH-1 it wraps to 0 and pass_cnt increments.
  - Accept with wr_idx==DEPTH-1 and pass_cnt==NUM_PASS-1: next state DRAIN, pass_cnt returns to 0, rd_idx=0.
  - in_valid=0: no state change; gaps of any length allowed.
- State DRAIN:
  - in_ready=0; in_valid/in_data ignored (no accumulation, no counter movement).
  - out_valid=1; out_data=buf[rd_idx]; out_last=(rd_idx==DEPTH-1).
  - out_data/out_last stable while out_valid && !out_ready (no drop, no change).
  - On output accept: rd_idx increments.
  - Output accept with rd_idx==DEPTH-1: next state ACCUM, rd_idx=0, tile_done=1 for exactly the next cycle.
- Latency and throughput:
  - First result valid the cycle after the final input accept.
  - Accumulation throughput 1 beat/cycle; drain throughput 1 beat/cycle with out_ready held high.
  - Tile turnaround: in_ready returns to 1 the cycle after the last output accept.
- Reset mid-operation: any partial pass or drain is abandoned. State and outputs return to reset values; no results emitted for the aborted tile.
- NUM_PASS=1: every beat overwrites; tile drains after DEPTH inputs.
- Counters use exact compares against DEPTH-1 and NUM_PASS-1; no wrap beyond the configured range.

Test Plan:
- Reset then idle: rst_n=0 mid-run -> outputs immediately at reset values, in_ready=1, out_valid=0, pass_cnt=0.
- Basic accumulation (DEPTH=16, NUM_PASS=4):
  - Stimulus: pass p drives in_data=i+p for position i, in_valid continuously high.
  - Required: 64 accepts, then out_data sequence 4i+6 for i=0..15.
  - Required: out_last only on the 16th beat; tile_done pulse one cycle after the last handshake.
- Backpressure and bubbles:
  - Stimulus: random in_valid gaps and random out_ready deasserts.
  - Required: identical results to the basic-accumulation case; out_data stable while stalled.
  - Required: in_ready=0 throughout DRAIN; in_valid pulses during DRAIN are not absorbed.
- Wraparound:
  - Stimulus: all passes drive in_data=32'h7FFF_FFFF.
  - Required: 4×(2^31-1) mod 2^32 = 32'hFFFF_FFFC per entry.
  - Stimulus: signed -5 and +3 alternating across 4 passes.
  - Required: 32'hFFFF_FFFC (-4).
- Back-to-back tiles:
  - Stimulus: second tile with different data starts immediately after tile_done.
  - Required: results reflect only the second tile (pass 0 overwrite verified).
- Reset mid-drain:
  - Stimulus: assert rst_n=0 after 5 output beats.
  - Required: out_valid drops immediately; after release, a fresh tile accumulates and drains correctly from rd_idx=0.
